dual_clock_fifo_wr_arbiter: RTL

//  Shares the write port of one dual_clock_fifo among N packet sources in the FIFO write-clock domain.
//  - Grants one source per packet using round-robin order.
//  - Starts a packet only when the FIFO has room for a maximum-length packet.
//  - Tags each FIFO word with {last, source_id} so the read side can demultiplex.
//  - Enforces a packet-length cap: truncates the packet and discards the source's remaining beats.

---
 rtl/dual_clock_fifo_wr_arbiter_pkg.sv | 15 +
 rtl/dual_clock_fifo_wr_arbiter_if.sv | 27 ++
 rtl/dual_clock_fifo_wr_arbiter_rr.sv | 31 +++
 rtl/dual_clock_fifo_wr_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dual_clock_fifo_wr_arbiter_pkg.sv
// Shared types for the dual-clock FIFO write-port arbiter.
// State encoding and tag-width helper.
package dcf_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DROP = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dual_clock_fifo_wr_arbiter_if.sv
// Per-source packet beat handshake bundle.
// Sources drive valid/last/data; the arbiter returns ready.
interface dual_clock_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;

  modport master (
    output i_req_valid,
    output i_req_last,
    output i_req_data,
    input  o_req_ready
  );

  modport slave (
    input  i_req_valid,
    input  i_req_last,
    input  i_req_data,
    output o_req_ready
  );

endinterface

// File: rtl/dual_clock_fifo_wr_arbiter_rr.sv
// Combinational round-robin pick: first request at or
// after the pointer, wrapping; one-hot plus encoded id.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] id,
  output logic                any
);

  always_comb begin
    int k;
    gnt = '0;
    id  = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        id     = ID_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/dual_clock_fifo_wr_arbiter.sv
// Packet-granular round-robin sharing of a FIFO write
// port, with {last,id} tagging and a length cap.
module dual_clock_fifo_wr_arbiter
  import dcf_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_PKT    = 16,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_arstn,
  dual_clock_fifo_wr_arbiter_if.slave  req,
  output logic                         o_fifo_we,
  output logic [DATA_WIDTH+ID_WIDTH:0] o_fifo_wdata,
  input  logic                         i_fifo_full,
  input  logic [ADDR_WIDTH-1:0]        i_fifo_wcnt,
  output logic [ID_WIDTH-1:0]          o_grant_id,
  output logic                         o_busy,
  output logic                         o_trunc
);

  localparam int CW = $clog2(MAX_PKT + 1);

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   ptr_q, gid_q, arb_id, ptr_nx;
  logic [NUM_REQ-1:0]    gnt_q, arb_gnt, ready;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH:0]   room;
  logic [DATA_WIDTH-1:0] d_g;
  logic arb_any, space_ok, v_g, l_g, cap;
  logic acc, start, done;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req (req.i_req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  // room is computed one bit wider so it cannot wrap
  assign room = {1'b0, {ADDR_WIDTH{1'b1}}}
              - {1'b0, i_fifo_wcnt};
  assign space_ok = (room >= (ADDR_WIDTH+1)'(MAX_PKT))
                  & ~i_fifo_full;

  assign v_g = |(req.i_req_valid & gnt_q);
  assign l_g = |(req.i_req_last & gnt_q);
  assign d_g = req.i_req_data[gid_q*DATA_WIDTH +: DATA_WIDTH];
  assign cap = (cnt_q == CW'(MAX_PKT - 1));

  assign ptr_nx = (gid_q == ID_WIDTH'(NUM_REQ - 1))
                ? '0 : gid_q + 1'b1;

  assign req.o_req_ready = ready;
  assign o_grant_id      = gid_q;
  assign o_busy          = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    ready        = '0;
    o_fifo_we    = 1'b0;
    o_fifo_wdata = '0;
    o_trunc      = 1'b0;
    acc          = 1'b0;
    start        = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any && space_ok) begin
          start   = 1'b1;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        ready        = gnt_q & {NUM_REQ{~i_fifo_full}};
        acc          = v_g & ~i_fifo_full;
        o_fifo_we    = acc;
        o_fifo_wdata = {l_g | cap, gid_q, d_g};
        if (acc && l_g) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (acc && cap) begin
          o_trunc = 1'b1;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // overflow beats are swallowed even when full
        ready = gnt_q;
        if (v_g && l_g) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        gid_q <= arb_id;
        gnt_q <= arb_gnt;
        cnt_q <= '0;
      end else if (acc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done) ptr_q <= ptr_nx;
    end
  end

endmodule
